pipe_commit_monitor: RTL and testbench
======================================

PIPE_COMMIT_MONITOR -- requirements
Module: pipe_commit_monitor

Interface
REQ-001 The block SHALL have parameter HALT_REPEAT, default 4: number of consecutive commits at the same PC that declares a halt.
REQ-002 The block SHALL have parameter TIMEOUT, default 64: number of commit-free cycles in RUN that declares a hang.
REQ-003 The block SHALL have parameter TRACE_DEPTH, default 8 (power of 2): number of entries in the register-write trace FIFO.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 wb_valid  input  1  the writeback stage holds a real instruction this cycle.
REQ-007 wb_flush  input  1  the writeback-stage instruction is squashed (bubble).
REQ-008 wb_regwrite  input  1  the writeback-stage instruction writes the register file.
REQ-009 wb_rd  input  5  destination register.
REQ-010 wb_data  input  32  writeback value.
REQ-011 wb_pc  input  32  PC of the writeback-stage instruction.
REQ-012 hdu_stall  input  1  the hazard detection unit is stalling the pipeline this cycle.
REQ-013 dbg_addr  input  5  mirror register-file read address.
REQ-014 dbg_data  output  32  mirror contents at dbg_addr (combinational read).
REQ-015 trace_rd_en  input  1  pop request for the trace FIFO.
REQ-016 trace_dout  output  37  head entry {rd[4:0], data[31:0]}, registered.
REQ-017 trace_empty  output  1  the FIFO holds no entries.
REQ-018 trace_overflow  output  1  sticky: at least one push was dropped.
REQ-019 retired_count  output  16  number of commits.
REQ-020 stall_count  output  16  number of stall cycles.
REQ-021 done  output  1  halt detected; sticky.
REQ-022 timeout  output  1  hang detected; sticky.

Function
REQ-023 A commit SHALL be defined as wb_valid=1 and wb_flush=0 in a cycle.
REQ-024 The FSM SHALL have the states IDLE, RUN, DONE and HANG, and SHALL enter IDLE on reset.
REQ-025 In IDLE, the first commit SHALL move the FSM to RUN and SHALL be fully processed in that cycle; stalls are not counted in IDLE.
REQ-026 In RUN, each commit SHALL increment retired_count and each hdu_stall=1 cycle SHALL increment stall_count; both counters saturate at 16'hFFFF.
REQ-027 A commit with wb_regwrite=1 and wb_rd!=0 SHALL write wb_data to mirror[wb_rd] and push {wb_rd, wb_data} into the FIFO; writes to rd=0 are ignored, and dbg_addr=0 always reads 0.
REQ-028 The mirror SHALL be write-then-read-next: a same-cycle dbg_data read returns the old value, and the new value is visible from the next cycle.
REQ-029 Halt detection: a repeat counter SHALL increment on each commit whose wb_pc equals the previous committed PC and reset to 0 on any other commit; when it reaches HALT_REPEAT-1 (i.e. HALT_REPEAT consecutive commits at one PC), the FSM SHALL go to DONE and done=1 from the next cycle.
REQ-030 Timeout: an idle counter SHALL clear on each commit and increment on each commit-free RUN cycle; when it reaches TIMEOUT, the FSM SHALL go to HANG and timeout=1 from the next cycle.
REQ-031 If a commit and the TIMEOUT threshold coincide in the same cycle, the commit SHALL win and the FSM stays in RUN.
REQ-032 In DONE and HANG, the counters, mirror and FIFO pushes SHALL be frozen, FIFO pops still operate, and only reset exits these states.
REQ-033 FIFO push when full SHALL drop the entry and set trace_overflow; push and pop in the same cycle when full SHALL succeed with no overflow.
REQ-034 FIFO pop when empty SHALL be ignored and trace_dout SHALL hold its value; on a valid pop, trace_dout SHALL present the popped entry from the next cycle.
REQ-035 The FIFO pointers SHALL wrap modulo TRACE_DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-036 With reset=0 at a clock edge, the block SHALL set: FSM=IDLE; retired_count=0, stall_count=0; done=0, timeout=0, trace_overflow=0; trace_empty=1, trace_dout=0; FIFO pointers=0; repeat and idle counters=0; all mirror entries=0.
REQ-037 Reset asserted mid-operation (any state) SHALL take priority over all same-cycle inputs.

Verification
REQ-038 Scenario 1: reset, then 5 commits writing r1..r5 = 10..50 -> retired_count=5, dbg_addr=3 gives 30, FIFO pops yield {1,10}..{5,50} in order.
REQ-039 Scenario 2: commits at PC 0x20 ×4 consecutively -> done=1 one cycle after the 4th; further commits leave retired_count at 4.
REQ-040 Scenario 3: one commit, then 64 idle cycles -> timeout=1; a commit in the 64th idle cycle instead keeps timeout=0.
REQ-041 Scenario 4: 10 writes with no pops (depth 8) -> 8 entries, trace_overflow=1; a push+pop on full -> no new overflow, count unchanged.
REQ-042 Scenario 5: hdu_stall=1 for 3 RUN cycles and 2 IDLE cycles, plus a wb_flush=1 commit attempt -> stall_count=3, retired_count unaffected by the flushed slot.
REQ-043 Scenario 6: write to r0 with data 0xFFFF_FFFF, then reset asserted in RUN -> dbg_data(r0)=0, no FIFO push; after reset all outputs at their reset values.

Source files
------------

// File: rtl/pipe_commit_monitor.sv
// ---------------------------------------------------------------------------
// pipe_commit_monitor
//
// Watches the writeback stage of an in-order pipeline. It counts retired
// instructions and stall cycles, keeps a shadow copy of the architectural
// register file, records every register write in a small trace FIFO, and
// flags a halt or a hang. A halt is several back-to-back commits at one PC.
// A hang is a long commit-free stretch.
//
// Ports
//   clk            in   1   clock, all state updates on the rising edge
//   reset          in   1   synchronous, active-low reset
//   wb_valid       in   1   writeback stage holds a real instruction
//   wb_flush       in   1   writeback instruction is squashed
//   wb_regwrite    in   1   writeback instruction writes the register file
//   wb_rd          in   5   destination register
//   wb_data        in  32   writeback value
//   wb_pc          in  32   PC of the writeback instruction
//   hdu_stall      in   1   hazard unit stalls the pipeline this cycle
//   dbg_addr       in   5   mirror read address
//   dbg_data       out 32   mirror contents at dbg_addr (combinational)
//   trace_rd_en    in   1   trace FIFO pop request
//   trace_dout     out 37   last popped entry {rd, data}, registered
//   trace_empty    out  1   trace FIFO holds no entries
//   trace_overflow out  1   sticky: a push was dropped because the FIFO was full
//   retired_count  out 16   commits seen (saturating)
//   stall_count    out 16   stall cycles seen in RUN (saturating)
//   done           out  1   halt detected (sticky until reset)
//   timeout        out  1   hang detected (sticky until reset)
//   dbg_state      out  2   current FSM state (IDLE=0, RUN=1, DONE=2, HANG=3)
//
// Trace pop handshake: the FIFO has no ready signal. trace_rd_en is a pop
// request. It takes effect on a rising edge only when trace_empty is low, and
// the popped entry appears on trace_dout after that edge. A request while
// the FIFO is empty is ignored, and trace_dout keeps its value.
// ---------------------------------------------------------------------------
module pipe_commit_monitor #(
    parameter int HALT_REPEAT = 4,
    parameter int TIMEOUT     = 64,
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_flush,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        hdu_stall,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        trace_rd_en,
    output logic [36:0] trace_dout,
    output logic        trace_empty,
    output logic        trace_overflow,
    output logic [15:0] retired_count,
    output logic [15:0] stall_count,
    output logic        done,
    output logic        timeout,
    output logic [1:0]  dbg_state
);

    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int RW = (HALT_REPEAT > 2) ? $clog2(HALT_REPEAT) : 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HANG = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    retired_q, retired_d;
    logic [15:0]    stall_q, stall_d;
    logic [RW-1:0]  repeat_q, repeat_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic [31:0]    prev_pc_q, prev_pc_d;
    logic           prev_vld_q, prev_vld_d;

    logic [31:0]    mirror_q [32];

    logic [36:0]    fifo_mem [TRACE_DEPTH];
    logic [PW:0]    wr_ptr_q, rd_ptr_q;
    logic [36:0]    dout_q;
    logic           ovf_q;

    logic           commit;
    logic           accept;
    logic           reg_we;
    logic           fifo_full;
    logic           fifo_empty;
    logic           do_pop;
    logic           do_push;
    logic           drop_push;

    assign commit = wb_valid & ~wb_flush;
    // Only IDLE and RUN consume commits. DONE and HANG freeze all bookkeeping.
    assign accept = commit & ((state_q == ST_IDLE) | (state_q == ST_RUN));
    assign reg_we = accept & wb_regwrite & (wb_rd != 5'd0);

    // The extra pointer bit separates full (MSBs differ) from empty (equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop     = trace_rd_en & ~fifo_empty;
    // When the FIFO is full, a pop in the same cycle frees the slot for the push.
    assign do_push    = reg_we & (~fifo_full | do_pop);
    assign drop_push  = reg_we & fifo_full & ~do_pop;

    always_comb begin
        state_d    = state_q;
        retired_d  = retired_q;
        stall_d    = stall_q;
        repeat_d   = repeat_q;
        idle_d     = idle_q;
        prev_pc_d  = prev_pc_q;
        prev_vld_d = prev_vld_q;

        if ((state_q == ST_RUN) && hdu_stall && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end

        if (accept) begin
            if (retired_q != 16'hFFFF) begin
                retired_d = retired_q + 16'd1;
            end
            if (prev_vld_q && (wb_pc == prev_pc_q)) begin
                repeat_d = repeat_q + RW'(1);
            end else begin
                repeat_d = '0;
            end
            prev_pc_d  = wb_pc;
            prev_vld_d = 1'b1;
            idle_d     = '0;
            // A commit resets the idle count, so it takes priority over a
            // timeout that would otherwise fire in the same cycle.
            if (repeat_d == RW'(HALT_REPEAT - 1)) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN) begin
            idle_d = idle_q + IW'(1);
            if (idle_d == IW'(TIMEOUT)) begin
                state_d = ST_HANG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            retired_q  <= '0;
            stall_q    <= '0;
            repeat_q   <= '0;
            idle_q     <= '0;
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            retired_q  <= retired_d;
            stall_q    <= stall_d;
            repeat_q   <= repeat_d;
            idle_q     <= idle_d;
            prev_pc_q  <= prev_pc_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    // A write lands at the clock edge. A same-cycle read still returns the
    // old value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mirror_q[i] <= '0;
            end
        end else if (reg_we) begin
            mirror_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= fifo_mem[rd_ptr_q[PW-1:0]];
            end
            if (drop_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // The storage array needs no reset. The pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= {wb_rd, wb_data};
        end
    end

    assign dbg_data       = (dbg_addr == 5'd0) ? 32'd0 : mirror_q[dbg_addr];
    assign trace_dout     = dout_q;
    assign trace_empty    = fifo_empty;
    assign trace_overflow = ovf_q;
    assign retired_count  = retired_q;
    assign stall_count    = stall_q;
    assign done           = (state_q == ST_DONE);
    assign timeout        = (state_q == ST_HANG);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pipe_commit_monitor.sv
module tb_pipe_commit_monitor;

    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        wb_valid = 1'b0;
    logic        wb_flush = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] wb_pc = '0;
    logic        hdu_stall = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        trace_rd_en = 1'b0;
    logic [36:0] trace_dout;
    logic        trace_empty;
    logic        trace_overflow;
    logic [15:0] retired_count;
    logic [15:0] stall_count;
    logic        done;
    logic        timeout;
    logic [1:0]  dbg_state;

    pipe_commit_monitor #(
        .HALT_REPEAT(4),
        .TIMEOUT(64),
        .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wb_valid(wb_valid),
        .wb_flush(wb_flush),
        .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .wb_pc(wb_pc),
        .hdu_stall(hdu_stall),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .trace_rd_en(trace_rd_en),
        .trace_dout(trace_dout),
        .trace_empty(trace_empty),
        .trace_overflow(trace_overflow),
        .retired_count(retired_count),
        .stall_count(stall_count),
        .done(done),
        .timeout(timeout),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail = 0;
    logic [36:0] exp_q[$];
    int          exp_retired = 0;
    bit          mdl_live = 1'b1;
    bit          mdl_ovf = 1'b0;
    logic [36:0] last_dout = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb_valid    = 1'b0;
        wb_flush    = 1'b0;
        wb_regwrite = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        wb_pc       = '0;
        hdu_stall   = 1'b0;
        trace_rd_en = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_retired = 0;
        mdl_live    = 1'b1;
        mdl_ovf     = 1'b0;
        last_dout   = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic commit(input logic [31:0] pc, input bit rw, input logic [4:0] rd,
                          input logic [31:0] data, input bit pop);
        bit          popping;
        logic [36:0] popped;
        popped      = '0;
        wb_valid    = 1'b1;
        wb_flush    = 1'b0;
        wb_regwrite = rw;
        wb_rd       = rd;
        wb_data     = data;
        wb_pc       = pc;
        trace_rd_en = pop;
        popping = pop && (exp_q.size() > 0);
        if (popping) begin
            popped    = exp_q.pop_front();
            last_dout = popped;
        end
        if (mdl_live) begin
            if (exp_retired < 65535) exp_retired++;
            if (rw && rd != 5'd0) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({rd, data});
                else mdl_ovf = 1'b1;
            end
        end
        tick();
        clear_inputs();
        if (popping) check_eq("push_pop_dout", trace_dout, popped);
    endtask

    task automatic idle_cycles(input int n, input bit stall);
        for (int i = 0; i < n; i++) begin
            hdu_stall = stall;
            tick();
            clear_inputs();
        end
    endtask

    task automatic pop_one(input string tag);
        trace_rd_en = 1'b1;
        if (exp_q.size() > 0) last_dout = exp_q.pop_front();
        tick();
        trace_rd_en = 1'b0;
        check_eq(tag, trace_dout, last_dout);
    endtask

    task automatic read_mirror(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check_eq(tag, dbg_data, exp);
    endtask

    task automatic check_reset_values();
        check_eq("rst_retired", retired_count, 0);
        check_eq("rst_stall", stall_count, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_overflow", trace_overflow, 0);
        check_eq("rst_empty", trace_empty, 1);
        check_eq("rst_dout", trace_dout, 0);
        check_eq("rst_state", dbg_state, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_extra;

        // Scenario 1: five register writes, mirror read-back, ordered pops.
        apply_reset();
        check_reset_values();
        for (int i = 1; i <= 5; i++) begin
            commit(32'h100 + 32'(4 * i), 1'b1, 5'(i), 32'(10 * i), 1'b0);
        end
        check_eq("s1_retired", retired_count, 16'(exp_retired));
        check_eq("s1_retired_const", retired_count, 5);
        check_eq("s1_state_run", dbg_state, 1);
        read_mirror("s1_mirror_r3", 5'd3, 32'd30);
        for (int i = 1; i <= 5; i++) pop_one("s1_pop");
        check_eq("s1_empty_after", trace_empty, 1);
        pop_one("s1_pop_empty_hold");
        // A same-cycle read returns the old value. The new value appears
        // after the edge.
        dbg_addr    = 5'd6;
        wb_valid    = 1'b1;
        wb_regwrite = 1'b1;
        wb_rd       = 5'd6;
        wb_data     = 32'd60;
        wb_pc       = 32'h200;
        #1;
        check_eq("s1_mirror_old", dbg_data, 0);
        exp_q.push_back({5'd6, 32'd60});
        exp_retired++;
        tick();
        clear_inputs();
        read_mirror("s1_mirror_new", 5'd6, 32'd60);
        pop_one("s1_pop_r6");

        // Scenario 2: halt detection. A different PC restarts the run.
        apply_reset();
        for (int i = 0; i < 3; i++) commit(32'h20, 1'b0, 5'd0, 32'd0, 1'b0);
        commit(32'h24, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) commit(32'h20, 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("s2_not_done_yet", done, 0);
        commit(32'h20, 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("s2_done", done, 1);
        check_eq("s2_state_done", dbg_state, 2);
        check_eq("s2_retired", retired_count, 16'(exp_retired));
        mdl_live = 1'b0;
        n_extra = $urandom_range(1, 3);
        for (int i = 0; i < n_extra; i++) commit(32'h20, 1'b1, 5'd4, 32'hDEAD, 1'b0);
        check_eq("s2_retired_frozen", retired_count, 8);
        check_eq("s2_no_push_frozen", trace_empty, 1);
        read_mirror("s2_mirror_frozen", 5'd4, 32'd0);

        // Scenario 3: timeout after 64 idle cycles.
        apply_reset();
        commit(32'h40, 1'b0, 5'd0, 32'd0, 1'b0);
        idle_cycles(63, 1'b0);
        check_eq("s3_timeout_63", timeout, 0);
        idle_cycles(1, 1'b0);
        check_eq("s3_timeout_64", timeout, 1);
        check_eq("s3_state_hang", dbg_state, 3);
        mdl_live = 1'b0;
        commit(32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("s3_retired_frozen", retired_count, 1);

        // Scenario 3b: a commit in the 64th idle cycle wins over the timeout.
        apply_reset();
        commit(32'h40, 1'b0, 5'd0, 32'd0, 1'b0);
        idle_cycles(63, 1'b0);
        commit(32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("s3b_timeout_coincide", timeout, 0);
        check_eq("s3b_state_run", dbg_state, 1);
        check_eq("s3b_retired", retired_count, 16'(exp_retired));
        idle_cycles(64, 1'b0);
        check_eq("s3b_timeout_later", timeout, 1);

        // Scenario 4a: fill exactly, then push and pop together when full.
        apply_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            commit(32'h300 + 32'(4 * i), 1'b1, 5'(i), 32'($urandom_range(0, 32'hFFFF)), 1'b0);
        end
        check_eq("s4a_no_ovf_full", trace_overflow, 0);
        commit(32'h380, 1'b1, 5'd20, 32'hABCD, 1'b1);
        check_eq("s4a_no_ovf_pushpop", trace_overflow, mdl_ovf);
        for (int i = 0; i < DEPTH; i++) pop_one("s4a_pop");
        check_eq("s4a_empty", trace_empty, 1);

        // Scenario 4b: ten writes with no pops. Two entries are dropped.
        apply_reset();
        for (int i = 1; i <= 10; i++) begin
            commit(32'h400 + 32'(4 * i), 1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0);
        end
        check_eq("s4b_overflow", trace_overflow, mdl_ovf);
        check_eq("s4b_overflow_set", trace_overflow, 1);
        check_eq("s4b_retired", retired_count, 16'(exp_retired));
        for (int i = 0; i < DEPTH; i++) pop_one("s4b_pop");
        check_eq("s4b_empty", trace_empty, 1);
        read_mirror("s4b_mirror_r10", 5'd10, 32'h100A);

        // Scenario 5: stalls in IDLE are ignored. A flushed slot is not a commit.
        apply_reset();
        idle_cycles(2, 1'b1);
        check_eq("s5_idle_stall", stall_count, 0);
        check_eq("s5_still_idle", dbg_state, 0);
        commit(32'h500, 1'b0, 5'd0, 32'd0, 1'b0);
        idle_cycles(3, 1'b1);
        wb_valid    = 1'b1;
        wb_flush    = 1'b1;
        wb_regwrite = 1'b1;
        wb_rd       = 5'd7;
        wb_data     = 32'h77;
        wb_pc       = 32'h504;
        tick();
        clear_inputs();
        check_eq("s5_stall_count", stall_count, 3);
        check_eq("s5_retired_flush", retired_count, 16'(exp_retired));
        check_eq("s5_flush_no_push", trace_empty, 1);
        read_mirror("s5_flush_no_write", 5'd7, 32'd0);

        // Scenario 6: r0 write ignored, then reset in RUN alongside a commit.
        apply_reset();
        commit(32'h600, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        read_mirror("s6_r0_zero", 5'd0, 32'd0);
        check_eq("s6_r0_no_push", trace_empty, 1);
        commit(32'h604, 1'b1, 5'd9, 32'h55, 1'b0);
        read_mirror("s6_r9", 5'd9, 32'h55);
        reset       = 1'b0;
        wb_valid    = 1'b1;
        wb_regwrite = 1'b1;
        wb_rd       = 5'd10;
        wb_data     = 32'h99;
        wb_pc       = 32'h608;
        hdu_stall   = 1'b1;
        trace_rd_en = 1'b1;
        tick();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        check_reset_values();
        read_mirror("s6_r9_cleared", 5'd9, 32'd0);
        read_mirror("s6_r10_not_written", 5'd10, 32'd0);
        idle_cycles(1, 1'b0);
        check_eq("s6_idle_holds", dbg_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // The run has a fixed length. This is a backstop against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
